seg_pattern_fsm: RTL

- Programmable string-pattern recogniser for the character-classifier pipeline.
- Consumes the per-character class flag vector and checks each \0-delimited string against a runtime-loaded sequence of up to NSEG segments.
- Each segment is defined by a class mask and a min..max repeat count.
- Reports one-cycle match/err pulses and exposes position for debug.

---
 rtl/seg_pattern_fsm.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/seg_pattern_fsm.sv
// seg_pattern_fsm: programmable string-pattern recogniser.
// Each \0-delimited string is checked against a runtime-loaded program of up
// to NSEG segments (class mask + min..max repeat count). One-cycle match/err
// pulses report the verdict; seg/run_cnt expose the matcher position.
// Optional build macro: SEG_PATTERN_CHAIN_EN (a terminating \0 also opens the
// next string instead of returning to IDLE).
module seg_pattern_fsm #(
    parameter int unsigned NSEG  = 4,
    parameter int unsigned CNT_W = 4,
    parameter int unsigned NCLS  = 14
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NCLS-1:0]          cls,
    input  logic                     valid,
    input  logic                     error_verify,
    input  logic                     cfg_we,
    input  logic [$clog2(NSEG)-1:0]  cfg_idx,
    input  logic [NCLS-1:0]          cfg_mask,
    input  logic [CNT_W-1:0]         cfg_min,
    input  logic [CNT_W-1:0]         cfg_max,
    input  logic                     cfg_len_we,
    input  logic [$clog2(NSEG):0]    cfg_len,
    output logic                     match,
    output logic                     err,
    output logic                     busy,
    output logic [$clog2(NSEG)-1:0]  seg,
    output logic [CNT_W-1:0]         run_cnt
);

    localparam int unsigned SEG_W = $clog2(NSEG);
    localparam int unsigned LEN_W = SEG_W + 1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_ERROR  = 2'd2
    } state_t;

    // Where a terminating \0 leads: straight into the next string, or IDLE.
`ifdef SEG_PATTERN_CHAIN_EN
    localparam state_t EOS_STATE = ST_ACTIVE;
`else
    localparam state_t EOS_STATE = ST_IDLE;
`endif
    localparam logic EOS_BUSY = (EOS_STATE != ST_IDLE);

    // Segment program
    logic [NCLS-1:0]  r_mask [NSEG];
    logic [CNT_W-1:0] r_min  [NSEG];
    logic [CNT_W-1:0] r_max  [NSEG];
    logic [LEN_W-1:0] r_len;

    // Matcher state and registered outputs
    state_t           r_state;
    logic [SEG_W-1:0] r_seg;
    logic [CNT_W-1:0] r_run;
    logic             r_match;
    logic             r_err;
    logic             r_busy;

    // Decoded character / program conditions
    logic             w_eos;
    logic [SEG_W-1:0] w_seg_nxt;
    logic             w_hit_cur;
    logic             w_hit_nxt;
    logic             w_last;
    logic             w_min_ok;
    logic             w_below_max;

    // Normalised configuration values
    logic [NCLS-1:0]  w_cfg_mask;
    logic [CNT_W-1:0] w_cfg_min;
    logic [CNT_W-1:0] w_cfg_max;
    logic             w_len_ok;

    assign w_eos       = valid & cls[0];
    assign w_seg_nxt   = r_seg + SEG_W'(1);
    assign w_hit_cur   = |(cls & r_mask[r_seg]);
    assign w_hit_nxt   = |(cls & r_mask[w_seg_nxt]);
    assign w_last      = ({1'b0, r_seg} == (r_len - LEN_W'(1)));
    assign w_min_ok    = (r_run >= r_min[r_seg]);
    assign w_below_max = (r_run < r_max[r_seg]);

    // Bit 0 (start_stop) never takes part in segment hits.
    assign w_cfg_mask  = cfg_mask & ~NCLS'(1);
    assign w_cfg_min   = (cfg_min == '0) ? CNT_W'(1) : cfg_min;
    assign w_cfg_max   = (cfg_max < w_cfg_min) ? w_cfg_min : cfg_max;
    assign w_len_ok    = (cfg_len >= LEN_W'(1)) && (cfg_len <= LEN_W'(NSEG));

    // Program storage: default vowel/consonant{2,3}/vowel, writable in IDLE only
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < NSEG; i++) begin
                r_mask[i] <= '0;
                r_min[i]  <= CNT_W'(1);
                r_max[i]  <= CNT_W'(1);
            end
            r_mask[0] <= NCLS'(1) << 11;
            r_mask[1] <= NCLS'(1) << 12;
            r_min[1]  <= CNT_W'(2);
            r_max[1]  <= CNT_W'(3);
            r_mask[2] <= NCLS'(1) << 11;
            r_len     <= LEN_W'(3);
        end else if (r_state == ST_IDLE) begin
            if (cfg_we) begin
                r_mask[cfg_idx] <= w_cfg_mask;
                r_min[cfg_idx]  <= w_cfg_min;
                r_max[cfg_idx]  <= w_cfg_max;
            end
            if (cfg_len_we && w_len_ok) begin
                r_len <= cfg_len;
            end
        end
    end

    // Recogniser FSM with registered pulses and position
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_seg   <= '0;
            r_run   <= '0;
            r_match <= 1'b0;
            r_err   <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_match <= 1'b0;
            r_err   <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_eos) begin
                        r_state <= ST_ACTIVE;
                        r_seg   <= '0;
                        r_run   <= '0;
                        r_busy  <= 1'b1;
                    end
                end
                ST_ACTIVE: begin
                    if (w_eos) begin
                        if (w_last && w_min_ok) begin
                            r_match <= 1'b1;
                        end else begin
                            r_err   <= 1'b1;
                        end
                        r_state <= EOS_STATE;
                        r_seg   <= '0;
                        r_run   <= '0;
                        r_busy  <= EOS_BUSY;
                    end else if (valid) begin
                        // Greedy: staying in the current segment wins over advancing.
                        if (w_hit_cur && w_below_max) begin
                            r_run <= r_run + CNT_W'(1);
                        end else if (w_min_ok && !w_last && w_hit_nxt) begin
                            r_seg <= w_seg_nxt;
                            r_run <= CNT_W'(1);
                        end else begin
                            r_state <= ST_ERROR;
                            r_err   <= 1'b1;
                        end
                    end
                end
                ST_ERROR: begin
                    if (error_verify) begin
                        r_state <= ST_IDLE;
                        r_seg   <= '0;
                        r_run   <= '0;
                        r_busy  <= 1'b0;
                    end else if (w_eos) begin
                        r_state <= EOS_STATE;
                        r_seg   <= '0;
                        r_run   <= '0;
                        r_busy  <= EOS_BUSY;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_seg   <= '0;
                    r_run   <= '0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign match   = r_match;
    assign err     = r_err;
    assign busy    = r_busy;
    assign seg     = r_seg;
    assign run_cnt = r_run;

endmodule
